// File: rtl/ppg_agc_controller.sv
`default_nettype none
// ============================================================================
// Module      : ppg_agc_controller
// Description : PPG front-end AGC that runs a DC-offset SAR search and a PGA
//               gain search, then tracks lock on the output window.
// Revision    : 1.0 - initial release
// ============================================================================
module ppg_agc_controller #(
    parameter int SETTLE_SAMPLES = 4,
    parameter int V_MID          = 128,
    parameter int V_LOW          = 64,
    parameter int V_HIGH         = 192,
    parameter int LOSS_COUNT     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sample_valid,
    input  logic [7:0] vppg,
    output logic [6:0] dc_comp,
    output logic [3:0] pga_gain,
    output logic       busy,
    output logic       locked,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_DC    = 3'd1;
    localparam logic [2:0] c_S_GAIN  = 3'd2;
    localparam logic [2:0] c_S_TRACK = 3'd3;
    localparam logic [2:0] c_S_FAULT = 3'd4;

    localparam int c_SET_W  = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES + 1) : 1;
    localparam int c_LOSS_W = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

    localparam logic [c_SET_W-1:0]  c_SETTLE_LAST = c_SET_W'(SETTLE_SAMPLES - 1);
    localparam logic [c_SET_W-1:0]  c_SET_ONE     = c_SET_W'(1);
    localparam logic [c_LOSS_W-1:0] c_LOSS_LAST   = c_LOSS_W'(LOSS_COUNT - 1);
    localparam logic [c_LOSS_W-1:0] c_LOSS_ONE    = c_LOSS_W'(1);
    localparam logic [7:0]          c_V_MID       = 8'(V_MID);
    localparam logic [7:0]          c_V_LOW       = 8'(V_LOW);
    localparam logic [7:0]          c_V_HIGH      = 8'(V_HIGH);

    logic [2:0]          r_state,  w_state_nx;
    logic [6:0]          r_dc,     w_dc_nx;
    logic [3:0]          r_gain,   w_gain_nx;
    logic [6:0]          r_trial,  w_trial_nx;
    logic [c_SET_W-1:0]  r_settle, w_settle_nx;
    logic [c_LOSS_W-1:0] r_loss,   w_loss_nx;
    logic                r_busy, r_locked, r_fault;
    logic                w_decide, w_in_win, w_restart;

    assign w_decide = sample_valid && (r_settle == c_SETTLE_LAST);
    assign w_in_win = (vppg >= c_V_LOW) && (vppg <= c_V_HIGH);

    always_comb begin
        w_state_nx  = r_state;
        w_dc_nx     = r_dc;
        w_gain_nx   = r_gain;
        w_trial_nx  = r_trial;
        w_settle_nx = r_settle;
        w_loss_nx   = r_loss;
        w_restart   = 1'b0;

        case (r_state)
            c_S_IDLE: begin
                if (start) w_restart = 1'b1;
            end
            c_S_DC: begin
                if (w_decide) begin
                    // Keep the trial bit only while vppg still sits above mid-scale.
                    w_dc_nx     = ((vppg > c_V_MID) ? r_dc : (r_dc & ~r_trial)) | (r_trial >> 1);
                    w_trial_nx  = r_trial >> 1;
                    w_settle_nx = '0;
                    if (r_trial[0]) begin
                        w_state_nx = c_S_GAIN;
                        w_gain_nx  = 4'd0;
                    end
                end else if (sample_valid) begin
                    w_settle_nx = r_settle + c_SET_ONE;
                end
            end
            c_S_GAIN: begin
                if (w_decide) begin
                    w_settle_nx = '0;
                    if (w_in_win) begin
                        w_state_nx = c_S_TRACK;
                        w_loss_nx  = '0;
                    end else if (vppg < c_V_LOW) begin
                        if (r_gain != 4'd15) w_gain_nx  = r_gain + 4'd1;
                        else                 w_state_nx = c_S_FAULT;
                    end else if (r_gain != 4'd0) begin
                        w_gain_nx  = r_gain - 4'd1;
                        w_state_nx = c_S_TRACK;
                        w_loss_nx  = '0;
                    end else begin
                        w_state_nx = c_S_FAULT;
                    end
                end else if (sample_valid) begin
                    w_settle_nx = r_settle + c_SET_ONE;
                end
            end
            c_S_TRACK: begin
                if (start) begin
                    w_restart = 1'b1;
                end else if (sample_valid) begin
                    if (w_in_win)                  w_loss_nx = '0;
                    else if (r_loss == c_LOSS_LAST) w_restart = 1'b1;
                    else                           w_loss_nx = r_loss + c_LOSS_ONE;
                end
            end
            c_S_FAULT: begin
                if (start) w_restart = 1'b1;
            end
            default: w_state_nx = c_S_IDLE;
        endcase

        if (w_restart) begin
            w_state_nx  = c_S_DC;
            w_dc_nx     = 7'h40;
            w_gain_nx   = 4'd0;
            w_trial_nx  = 7'h40;
            w_settle_nx = '0;
            w_loss_nx   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_S_IDLE;
            r_dc     <= 7'd0;
            r_gain   <= 4'd0;
            r_trial  <= 7'd0;
            r_settle <= '0;
            r_loss   <= '0;
            r_busy   <= 1'b0;
            r_locked <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_dc     <= w_dc_nx;
            r_gain   <= w_gain_nx;
            r_trial  <= w_trial_nx;
            r_settle <= w_settle_nx;
            r_loss   <= w_loss_nx;
            r_busy   <= (w_state_nx == c_S_DC) || (w_state_nx == c_S_GAIN);
            r_locked <= (w_state_nx == c_S_TRACK);
            r_fault  <= (w_state_nx == c_S_FAULT);
        end
    end

    assign state    = r_state;
    assign dc_comp  = r_dc;
    assign pga_gain = r_gain;
    assign busy     = r_busy;
    assign locked   = r_locked;
    assign fault    = r_fault;

endmodule
`default_nettype wire

// File: doc/ppg_agc_controller.md
PPG_AGC_CONTROLLER -- requirements
Module: ppg_agc_controller

Interface
REQ-001 Parameter SETTLE_SAMPLES, default 4: valid samples consumed per settle window before a decision.
REQ-002 Parameter V_MID, default 128: DC-search decision threshold.
REQ-003 Parameter V_LOW, default 64, and V_HIGH, default 192: inclusive lock window on vppg.
REQ-004 Parameter LOSS_COUNT, default 8: consecutive out-of-window samples that break lock.
REQ-005 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-006 Port rst, input, 1: reset; synchronous and active-high.
REQ-007 Port start, input, 1: one-cycle calibration request.
REQ-008 Port sample_valid, input, 1: vppg holds a new front-end sample this cycle.
REQ-009 Port vppg, input, 8: unsigned PPG front-end output code.
REQ-010 Port dc_comp, output, 7: DC compensation code to front end; a higher code lowers vppg.
REQ-011 Port pga_gain, output, 4: PGA gain code to front end; a higher code raises vppg swing.
REQ-012 Port busy, output, 1: high in DC_SEARCH and GAIN_SEARCH.
REQ-013 Port locked, output, 1: high only in TRACK.
REQ-014 Port fault, output, 1: high only in FAULT.
REQ-015 Port state, output, 3: IDLE=0, DC_SEARCH=1, GAIN_SEARCH=2, TRACK=3, FAULT=4.

Function
REQ-016 All outputs SHALL be registered, and state SHALL change only on clk rising edges.
REQ-017 Settle counter SHALL count sample_valid pulses; a decision SHALL use vppg from the cycle of the SETTLE_SAMPLES-th pulse, and the counter SHALL clear after each decision.
REQ-018 IDLE: start=1 SHALL move to DC_SEARCH next cycle with dc_comp=7'h40, pga_gain=0, and the settle counter cleared.
REQ-019 DC_SEARCH SHALL run a 7-step successive approximation, MSB (bit 6) to LSB (bit 0), with one decision per settle window.
REQ-020 Each DC decision SHALL keep the trial bit if vppg > V_MID, else clear it, and SHALL set the next lower bit in the same update.
REQ-021 After the bit-0 decision, the block SHALL enter GAIN_SEARCH next cycle with dc_comp final and pga_gain=0.
REQ-022 GAIN_SEARCH, per decision: V_LOW <= vppg <= V_HIGH -> TRACK.
REQ-023 GAIN_SEARCH, per decision: vppg < V_LOW with gain < 15 -> gain+1 and stay in GAIN_SEARCH.
REQ-024 GAIN_SEARCH, per decision: vppg < V_LOW with gain = 15 -> FAULT.
REQ-025 GAIN_SEARCH, per decision: vppg > V_HIGH with gain > 0 -> gain-1, then TRACK.
REQ-026 GAIN_SEARCH, per decision: vppg > V_HIGH with gain = 0 -> FAULT.
REQ-027 pga_gain SHALL never wrap; 15+1 and 0-1 are excluded by REQ-024 and REQ-026.
REQ-028 TRACK: each sample_valid with vppg outside [V_LOW, V_HIGH] SHALL increment a loss counter; any in-window sample SHALL clear it.
REQ-029 TRACK: when the loss counter reaches LOSS_COUNT, locked SHALL drop and the block SHALL restart as in REQ-018 on the next cycle.
REQ-030 FAULT: dc_comp and pga_gain SHALL hold; start SHALL restart as in REQ-018.
REQ-031 TRACK: start SHALL restart as in REQ-018; start during DC_SEARCH or GAIN_SEARCH SHALL be ignored.
REQ-032 Simultaneous start and loss threshold in TRACK SHALL produce a single restart, identical to REQ-018.
REQ-033 Cycles without sample_valid SHALL hold all state and counters in every state.

Reset
REQ-034 rst=1 SHALL, at the next edge, force IDLE, dc_comp=0, pga_gain=0, busy=0, locked=0, fault=0, and clear the settle and loss counters.
REQ-035 rst SHALL override start and sample_valid, including when asserted mid-search or mid-track.

Verification
REQ-036 Reset: assert rst mid-DC_SEARCH -> next cycle state=0, dc_comp=0, pga_gain=0, all flags 0.
REQ-037 vppg held at 200, start -> after 28 valid samples dc_comp=127, then GAIN_SEARCH decision 200>192 at gain 0 -> FAULT, fault=1.
REQ-038 vppg held at 100, start -> dc_comp=0 after 7 decisions; first gain decision in window -> TRACK, locked=1, pga_gain=0.
REQ-039 vppg held at 30 -> dc_comp=0, pga_gain steps 0..15 over 16 decisions -> FAULT with pga_gain=15.
REQ-040 In TRACK, 7 samples at 250 then 1 at 100 -> still locked; then 8 samples at 250 -> locked=0, state=1, dc_comp=64.
REQ-041 start pulsed during DC_SEARCH -> ignored, search sequence and dc_comp trajectory unchanged.
